// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MIPS memory stage: store sizes, load extension,
// write-back selects and the MEM/WB register layout.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_WORD = 2'b01,
    ST_HALF = 2'b10,
    ST_BYTE = 2'b11
  } st_size_e;

  typedef enum logic [1:0] {
    LD_WORD   = 2'b00,
    LD_HALF_S = 2'b01,
    LD_BYTE_S = 2'b10,
    LD_BYTE_U = 2'b11
  } ld_ext_e;

  typedef enum logic [2:0] {
    WB_ALU = 3'b000,
    WB_MEM = 3'b001,
    WB_PC4 = 3'b010,
    WB_HI  = 3'b011,
    WB_LO  = 3'b100
  } wb_sel_e;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic        reg_write;
    logic [31:0] data;
    logic [4:0]  reg_addr;
    logic        addr_err;
  } mem_wb_t;

endpackage

// File: rtl/data_mem_be.sv
// Word-organised data memory: synchronous byte-enable write, asynchronous read.
// Byte-enable bit b covers data bits [8b+7:8b], so be_i[3] is big-endian lane 0.
module data_mem_be #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  // NOTE: the array has no reset on purpose; clearing it would need a per-word
  // reset network and no consumer relies on initial contents.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch redirect, data memory access,
// Hi/Lo architectural registers and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_LSB  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cBranch,
  input  logic        cPCMux,
  input  logic [1:0]  cMemWrite,
  input  logic        cMemRead,
  input  logic [1:0]  cSEMux,
  input  logic        cMove,
  input  logic        cRegWriteCtrl,
  input  logic [2:0]  cMemToReg,
  input  logic        cRegAddress,
  input  logic        cZero,
  input  logic        HiLoWrite,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] PCSumImm,
  input  logic [31:0] ALUResult,
  input  logic [31:0] Hi,
  input  logic [31:0] Lo,
  input  logic [31:0] ReadReg2,
  input  logic [63:0] HiLoResult,
  input  logic [4:0]  RegDstResult,
  output logic        oPCSrc,
  output logic [31:0] oPCTarget,
  output logic [31:0] oHiReg,
  output logic [31:0] oLoReg,
  output logic        oRegWrite,
  output logic [31:0] oWriteData,
  output logic [4:0]  oWriteReg,
  output logic        oAddrErr
);

  localparam int AW = $clog2(MEM_WORDS);

  st_size_e    st_size;
  ld_ext_e     ld_ext;
  logic [1:0]  lane;
  logic [AW-1:0] word_idx;
  logic        st_misaligned;
  logic        ld_misaligned;
  logic        addr_err;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  mem_wb_t     wb_d, wb_q;
  logic [31:0] hi_q, lo_q;
  logic        unused_addr_bits;

  assign st_size  = st_size_e'(cMemWrite);
  assign ld_ext   = ld_ext_e'(cSEMux);
  assign lane     = ALUResult[1:0];
  assign word_idx = ALUResult[ADDR_LSB+AW-1:ADDR_LSB];
  assign unused_addr_bits = ^ALUResult[31:ADDR_LSB+AW];

  assign oPCSrc    = cPCMux | (cBranch & cZero);
  assign oPCTarget = PCSumImm;

  always_comb begin
    st_misaligned = 1'b0;
    case (st_size)
      ST_WORD: st_misaligned = (lane != 2'b00);
      ST_HALF: st_misaligned = lane[0];
      default: st_misaligned = 1'b0;
    endcase
    ld_misaligned = 1'b0;
    if (cMemRead) begin
      case (ld_ext)
        LD_WORD:   ld_misaligned = (lane != 2'b00);
        LD_HALF_S: ld_misaligned = lane[0];
        default:   ld_misaligned = 1'b0;
      endcase
    end
  end

  assign addr_err = st_misaligned | ld_misaligned;

  // Store lane steering; Reset low or a misaligned address leaves every lane untouched.
  always_comb begin
    be    = 4'b0000;
    wdata = ReadReg2;
    case (st_size)
      ST_WORD: be = 4'b1111;
      ST_HALF: begin
        be    = lane[1] ? 4'b0011 : 4'b1100;
        wdata = {2{ReadReg2[15:0]}};
      end
      ST_BYTE: begin
        be    = 4'b1000 >> lane;
        wdata = {4{ReadReg2[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    if (st_misaligned || !Reset) begin
      be = 4'b0000;
    end
  end

  data_mem_be #(
    .MEM_WORDS(MEM_WORDS)
  ) u_dmem (
    .clk_i  (Clk),
    .addr_i (word_idx),
    .be_i   (be),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );

  // NOTE: every always_comb output gets a default before any branch so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    lane_half = lane[1] ? rdata[15:0] : rdata[31:16];
    lane_byte = rdata[31:24];
    case (lane)
      2'd0:    lane_byte = rdata[31:24];
      2'd1:    lane_byte = rdata[23:16];
      2'd2:    lane_byte = rdata[15:8];
      default: lane_byte = rdata[7:0];
    endcase
    load_val = rdata;
    case (ld_ext)
      LD_WORD:   load_val = rdata;
      LD_HALF_S: load_val = {{16{lane_half[15]}}, lane_half};
      LD_BYTE_S: load_val = {{24{lane_byte[7]}}, lane_byte};
      LD_BYTE_U: load_val = {24'h0, lane_byte};
      default:   load_val = rdata;
    endcase
    if (ld_misaligned) begin
      load_val = '0;
    end
  end

  // Hi/Lo feed the write-back mux from the EX operands, so mfhi sees forwarded data.
  always_comb begin
    wb_d           = '0;
    wb_d.addr_err  = addr_err;
    wb_d.reg_addr  = cRegAddress ? LINK_REG : RegDstResult;
    wb_d.reg_write = (cMove ? (cRegWriteCtrl & ~cZero) : cRegWriteCtrl) & ~addr_err;
    case (wb_sel_e'(cMemToReg))
      WB_ALU:  wb_d.data = ALUResult;
      WB_MEM:  wb_d.data = load_val;
      WB_PC4:  wb_d.data = PCPlus4;
      WB_HI:   wb_d.data = Hi;
      WB_LO:   wb_d.data = Lo;
      default: wb_d.data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wb_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      wb_q <= wb_d;
      if (HiLoWrite) begin
        hi_q <= HiLoResult[63:32];
        lo_q <= HiLoResult[31:0];
      end
    end
  end

  assign oRegWrite  = wb_q.reg_write;
  assign oWriteData = wb_q.data;
  assign oWriteReg  = wb_q.reg_addr;
  assign oAddrErr   = wb_q.addr_err;
  assign oHiReg     = hi_q;
  assign oLoReg     = lo_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline; sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Resolves the branch/jump redirect for fetch.
- Performs word/half/byte loads and stores on an internal data memory.
- Owns the architectural Hi/Lo registers and selects the write-back value and destination.
- Holds the MEM/WB pipeline register.

Parameters:
- MEM_WORDS, 1024, data memory depth in 32-bit words; must be a power of 2.
- ADDR_LSB, 2, byte-offset bits dropped to form the word index.

Ports:
- Clk  in  1  pipeline clock; everything samples on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cBranch  in  1  conditional branch.
- cPCMux  in  1  unconditional jump.
- cMemWrite  in  2  store size: 00 none, 01 word, 10 half, 11 byte.
- cMemRead  in  1  load.
- cSEMux  in  2  load extend: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
- cMove  in  1  conditional move (movn/movz); write gated by cZero.
- cRegWriteCtrl  in  1  register-file write request.
- cMemToReg  in  3  write-back select: 000 ALU, 001 load, 010 PC+4, 011 Hi, 100 Lo; others 0.
- cRegAddress  in  1  1 forces destination register 31 (link).
- cZero  in  1  ALU zero flag.
- HiLoWrite  in  1  commit HiLoResult to Hi/Lo.
- PCPlus4, PCSumImm, ALUResult, Hi, Lo, ReadReg2  in  32 each  EX/MEM data.
- HiLoResult  in  64  {Hi,Lo} candidate.
- RegDstResult  in  5  destination register.
- oPCSrc  out  1  redirect fetch (combinational).
- oPCTarget  out  32  redirect address (combinational) = PCSumImm.
- oHiReg, oLoReg  out  32 each  architectural Hi/Lo, fed back to decode/EX.
- oRegWrite  out  1  MEM/WB registered write enable.
- oWriteData  out  32  MEM/WB registered write-back value.
- oWriteReg  out  5  MEM/WB registered destination register.
- oAddrErr  out  1  MEM/WB registered misaligned-access flag.

Behaviour:
- Reset low asynchronously clears oRegWrite, oWriteData, oWriteReg, oAddrErr, oHiReg and oLoReg to 0. Memory contents are not cleared. Release is synchronous to the next Clk edge.
- oPCSrc = cPCMux | (cBranch & cZero). It is combinational, with zero latency to fetch.
- Address:
  - Word index = ALUResult[ADDR_LSB+log2(MEM_WORDS)-1 : ADDR_LSB]. Upper bits are ignored, so the address wraps modulo the memory size.
  - Byte lane = ALUResult[1:0]. Memory is big-endian: lane 0 = bits 31:24.
- Misalignment: word access with ALUResult[1:0]!=0, or half access with ALUResult[0]!=0, sets the error condition.
- Store:
  - Byte-enable write on the rising edge when cMemWrite!=00, the access is aligned and Reset is high.
  - Half writes ReadReg2[15:0] to lanes {0,1} or {2,3}. Byte writes ReadReg2[7:0] to its lane.
  - A misaligned store is suppressed and no lanes change.
- Load:
  - Combinational array read, lane-extracted and extended per cSEMux, then captured into oWriteData. Load-to-WB latency is 1 cycle.
  - A misaligned load returns 0.
  - Same-cycle store and load to the same word: the load sees the pre-store data (read-before-write).
- oAddrErr is registered high for one cycle per misaligned cMemRead or cMemWrite access. When it is set, oRegWrite is forced to 0.
- Write enable:
  - cMove=0: oRegWrite <= cRegWriteCtrl.
  - cMove=1: oRegWrite <= cRegWriteCtrl & ~cZero.
- oWriteReg <= cRegAddress ? 5'd31 : RegDstResult.
- oWriteData mux uses the incoming Hi/Lo operands, not oHiReg/oLoReg. An mfhi therefore sees the value EX forwarded.
- Hi/Lo update: if HiLoWrite, then on the edge oHiReg <= HiLoResult[63:32] and oLoReg <= HiLoResult[31:0]; otherwise they hold.
- Simultaneous HiLoWrite and cMemToReg=011 in the same cycle: oWriteData takes the Hi input (old value), and oHiReg takes the new value.
- Reset mid-store: no write occurs while Reset is low.

Decomposition:
- Shared package holds these constants:
  - store sizes (ST_NONE/WORD/HALF/BYTE)
  - load extend codes (LD_WORD/HALF_S/BYTE_S/BYTE_U)
  - write-back selects (WB_ALU/MEM/PC4/HI/LO)
  - LINK_REG = 31
- One sub-module, data_mem_be: byte-enable synchronous-write, asynchronous-read word array, parameterised by MEM_WORDS.
- Lane extraction, the MEM/WB register and Hi/Lo registers stay in mem_stage.

Test Plan:
- Word store then load: store with ALUResult=0x10, ReadReg2=0xDEADBEEF; next cycle load word from 0x10 with cMemToReg=001 -> one cycle later oWriteData=0xDEADBEEF, oRegWrite=1.
- Byte and half loads: same data, then:
  - byte signed @0x11 -> 0xFFFFFFAD
  - byte unsigned @0x11 -> 0x000000AD
  - half signed @0x12 -> 0xFFFFBEEF
- Misaligned accesses:
  - word store @0x12 -> memory word 0x10 unchanged, oAddrErr=1 for one cycle, oRegWrite=0.
  - half load @0x13 -> oWriteData=0, oAddrErr=1.
- Branch/jump redirect:
  - cBranch=1, cZero=1, PCSumImm=0x40 -> oPCSrc=1, oPCTarget=0x40 in the same cycle.
  - cBranch=1, cZero=0 -> oPCSrc=0.
  - cPCMux=1 -> oPCSrc=1.
- Hi/Lo, link and conditional move:
  - HiLoWrite=1, HiLoResult=0x1_00000002 -> oHiReg=1, oLoReg=2 after the edge.
  - cRegAddress=1, cMemToReg=010, PCPlus4=0x8 -> oWriteReg=31, oWriteData=0x8.
  - cMove=1, cZero=1 -> oRegWrite=0.
- Async reset: drop Reset mid-cycle during a store -> all outputs 0 immediately, and the addressed memory word is unchanged.
